// File: rtl/pq_uart_pkg.sv
// Shared definitions for the power-quality UART path: scheduler FSM encoding,
// value width and the ASCII framing bytes emitted by the transmit side.
package pq_uart_pkg;

  localparam int VAL_W = 16;
  localparam int CH_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_SEP  = 8'h2C;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/uart_channel_scheduler_if.sv
// Bundle of requester-side and transmit-side signals around the scheduler.
// master = scheduler, slave = requesters plus transmit datapath.
interface uart_channel_scheduler_if
  import pq_uart_pkg::*;
#(
  parameter int N_CH = 4
) ();

  logic [N_CH-1:0]       req;
  logic [VAL_W*N_CH-1:0] val;
  logic [N_CH-1:0]       ack;
  logic                  tx_start;
  logic [VAL_W-1:0]      tx_val;
  logic [CH_W-1:0]       tx_ch;
  logic                  tx_done;
  logic                  busy;
  logic                  timeout_err;

  modport master (
    input  req, val, tx_done,
    output ack, tx_start, tx_val, tx_ch, busy, timeout_err
  );

  modport slave (
    output req, val, tx_done,
    input  ack, tx_start, tx_val, tx_ch, busy, timeout_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority pick: first set request searching from last_grant+1 upward,
// wrapping modulo N_CH. Purely combinational.
module rr_arbiter
  import pq_uart_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] last_grant_i,
  output logic [CH_W-1:0] grant_o,
  output logic            any_req_o
);

  logic [(1<<CH_W)-1:0] req_ext;
  logic [CH_W-1:0]      idx;

  always_comb begin
    req_ext             = '0;
    req_ext[N_CH-1:0]   = req_i;
    any_req_o           = |req_i;
    grant_o             = last_grant_i;
    idx                 = '0;
    // Walk from farthest to nearest so the nearest set request wins.
    for (int i = N_CH; i >= 1; i--) begin
      idx = CH_W'((int'(last_grant_i) + i) % N_CH);
      if (req_ext[idx]) grant_o = idx;
    end
  end

endmodule

// File: rtl/uart_channel_scheduler.sv
// Round-robin scheduler sharing one UART transmit path among N_CH requesters,
// with a saturating watchdog on the done handshake and an optional idle gap.
module uart_channel_scheduler
  import pq_uart_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 2000000,
  parameter int GAP     = 0
) (
  input logic                      clk,
  input logic                      rst,
  uart_channel_scheduler_if.master bus
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int GW = $clog2(GAP + 1) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = (GAP > 0) ? GW'(GAP - 1) : '0;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  last_grant_q, last_grant_d;
  logic [CH_W-1:0]  tx_ch_q, tx_ch_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [VAL_W-1:0] tx_val_q, tx_val_d;
  logic [N_CH-1:0]  ack_q, ack_d;
  logic             tx_start_q, tx_start_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;

  logic [CH_W-1:0]  grant;
  logic             any_req;
  logic [VAL_W-1:0] grant_val;
  logic             timeout_hit;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req_i        (bus.req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .any_req_o    (any_req)
  );

  always_comb begin
    grant_val = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant == CH_W'(k)) grant_val = bus.val[VAL_W*k +: VAL_W];
    end
  end

  assign timeout_hit = (timer_q == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= CH_W'(N_CH - 1);
      tx_ch_q       <= '0;
      timer_q       <= '0;
      gap_q         <= '0;
      tx_val_q      <= '0;
      ack_q         <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      tx_ch_q       <= tx_ch_d;
      timer_q       <= timer_d;
      gap_q         <= gap_d;
      tx_val_q      <= tx_val_d;
      ack_q         <= ack_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (bus.tx_done || timeout_hit) state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:    if (gap_q == GAP_LAST) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_comb begin
    last_grant_d  = last_grant_q;
    tx_ch_d       = tx_ch_q;
    tx_val_d      = tx_val_q;
    timer_d       = timer_q;
    gap_d         = gap_q;
    ack_d         = '0;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;
    busy_d        = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          tx_val_d     = grant_val;
          tx_ch_d      = grant;
          last_grant_d = grant;
          ack_d        = N_CH'(1) << grant;
          tx_start_d   = 1'b1;
        end
      end
      ST_LAUNCH: timer_d = '0;
      ST_WAIT: begin
        if (timer_q != '1) timer_d = timer_q + 1'b1;
        if (!bus.tx_done && timeout_hit) timeout_err_d = 1'b1;
        gap_d = '0;
      end
      ST_GAP:  gap_d = gap_q + 1'b1;
      default: ;
    endcase
  end

  assign bus.ack         = ack_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_val      = tx_val_q;
  assign bus.tx_ch       = tx_ch_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_channel_scheduler.sv
// Directed bench: dut_a (TIMEOUT=100, GAP=0) and dut_b (TIMEOUT=100, GAP=8).
module tb_uart_channel_scheduler;
  import pq_uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  uart_channel_scheduler_if #(.N_CH(4)) ifa ();
  uart_channel_scheduler_if #(.N_CH(4)) ifb ();

  uart_channel_scheduler #(.N_CH(4), .TIMEOUT(100), .GAP(0)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  uart_channel_scheduler #(.N_CH(4), .TIMEOUT(100), .GAP(8)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifa.req = '0; ifa.tx_done = 1'b0;
    ifb.req = '0; ifb.tx_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic a_wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifa.tx_start !== 1'b1 && n < 300);
  endtask

  task automatic b_wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifb.tx_start !== 1'b1 && n < 300);
  endtask

  task automatic a_pulse_done();
    @(negedge clk); ifa.tx_done = 1'b1;
    @(negedge clk); ifa.tx_done = 1'b0;
  endtask

  task automatic b_pulse_done();
    @(negedge clk); ifb.tx_done = 1'b1;
    @(negedge clk); ifb.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (ifa.ack !== 4'b0000) begin n_fail++; $display("FAIL rst_ack got=%b exp=0000", ifa.ack); end
    n_tests++; if (ifa.tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_start got=%b exp=0", ifa.tx_start); end
    n_tests++; if (ifa.tx_val !== 16'd0) begin n_fail++; $display("FAIL rst_val got=%0d exp=0", ifa.tx_val); end
    n_tests++; if (ifa.tx_ch !== 3'd0) begin n_fail++; $display("FAIL rst_ch got=%0d exp=0", ifa.tx_ch); end
    n_tests++; if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b%b exp=00", ifa.busy, ifb.busy); end
    n_tests++; if (ifa.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_terr got=%b exp=0", ifa.timeout_err); end
  endtask

  task automatic test_single();
    int n;
    ifa.val = '0;
    ifa.val[15:0] = 16'd1234;
    ifa.req = 4'b0001;
    a_wait_start(n);
    n_tests++; if (ifa.tx_start !== 1'b1 || n != 1) begin n_fail++; $display("FAIL t1_latency got=%0d start=%b exp=1", n, ifa.tx_start); end
    n_tests++; if (ifa.ack !== 4'b0001) begin n_fail++; $display("FAIL t1_ack got=%b exp=0001", ifa.ack); end
    n_tests++; if (ifa.tx_val !== 16'd1234) begin n_fail++; $display("FAIL t1_val got=%0d exp=1234", ifa.tx_val); end
    n_tests++; if (ifa.tx_ch !== 3'd0) begin n_fail++; $display("FAIL t1_ch got=%0d exp=0", ifa.tx_ch); end
    ifa.req = 4'b0000;
    repeat (49) @(negedge clk);
    n_tests++; if (ifa.busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_wait got=%b exp=1", ifa.busy); end
    a_pulse_done();
    n_tests++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_idle got=%b exp=0", ifa.busy); end
    n_tests++; if (ifa.timeout_err !== 1'b0) begin n_fail++; $display("FAIL t1_terr got=%b exp=0", ifa.timeout_err); end
  endtask

  task automatic test_back_to_back();
    int n;
    int c;
    do_reset();
    ifa.val = {16'd40, 16'd30, 16'd20, 16'd10};
    ifa.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      c = k % 4;
      a_wait_start(n);
      n_tests++; if (ifa.tx_start !== 1'b1 || n != 1) begin n_fail++; $display("FAIL t2_spacing k=%0d got=%0d exp=1", k, n); end
      n_tests++; if (ifa.tx_val !== 16'((c + 1) * 10)) begin n_fail++; $display("FAIL t2_val k=%0d got=%0d exp=%0d", k, ifa.tx_val, (c + 1) * 10); end
      n_tests++; if (ifa.ack !== 4'(1 << c)) begin n_fail++; $display("FAIL t2_ack k=%0d got=%b exp=%b", k, ifa.ack, 4'(1 << c)); end
      n_tests++; if (ifa.tx_ch !== 3'(c)) begin n_fail++; $display("FAIL t2_ch k=%0d got=%0d exp=%0d", k, ifa.tx_ch, c); end
      @(negedge clk);
      n_tests++; if (ifa.ack !== 4'b0000 || ifa.tx_start !== 1'b0) begin n_fail++; $display("FAIL t2_pulse k=%0d ack=%b start=%b exp=0000/0", k, ifa.ack, ifa.tx_start); end
      repeat (3) @(negedge clk);
      @(negedge clk); ifa.tx_done = 1'b1;
      @(negedge clk); ifa.tx_done = 1'b0;
      if (k == 4) ifa.req = 4'b0000;
    end
    repeat (3) @(negedge clk);
    n_tests++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL t2_idle got=%b exp=0", ifa.busy); end
  endtask

  task automatic test_timeout();
    int n;
    bit early;
    ifa.val[15:0] = 16'd321;
    ifa.req = 4'b0001;
    a_wait_start(n);
    n_tests++; if (ifa.tx_start !== 1'b1) begin n_fail++; $display("FAIL t3_start got=%b exp=1", ifa.tx_start); end
    ifa.req = 4'b0000;
    early = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (ifa.timeout_err !== 1'b0) early = 1'b1;
    end
    n_tests++; if (early) begin n_fail++; $display("FAIL t3_early got=1 exp=0"); end
    @(negedge clk);
    n_tests++; if (ifa.timeout_err !== 1'b1) begin n_fail++; $display("FAIL t3_terr got=%b exp=1", ifa.timeout_err); end
    n_tests++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL t3_busy got=%b exp=0", ifa.busy); end
    @(negedge clk);
    n_tests++; if (ifa.timeout_err !== 1'b0) begin n_fail++; $display("FAIL t3_terr_pulse got=%b exp=0", ifa.timeout_err); end
    ifa.val[31:16] = 16'd555;
    ifa.req = 4'b0010;
    a_wait_start(n);
    n_tests++; if (ifa.tx_start !== 1'b1 || ifa.tx_ch !== 3'd1 || ifa.tx_val !== 16'd555) begin n_fail++; $display("FAIL t3_next start=%b ch=%0d val=%0d exp=1/1/555", ifa.tx_start, ifa.tx_ch, ifa.tx_val); end
    ifa.req = 4'b0000;
    a_pulse_done();
  endtask

  task automatic test_done_vs_timeout();
    int n;
    bit bad;
    ifa.req = 4'b0001;
    a_wait_start(n);
    ifa.req = 4'b0000;
    repeat (99) @(negedge clk);
    @(negedge clk); ifa.tx_done = 1'b1;
    @(negedge clk); ifa.tx_done = 1'b0;
    n_tests++; if (ifa.timeout_err !== 1'b0) begin n_fail++; $display("FAIL t4_coincide got=%b exp=0", ifa.timeout_err); end
    n_tests++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL t4_busy got=%b exp=0", ifa.busy); end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ifa.timeout_err !== 1'b0) bad = 1'b1;
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL t4_late_terr got=1 exp=0"); end
    a_pulse_done();
    n_tests++; if (ifa.busy !== 1'b0 || ifa.tx_start !== 1'b0 || ifa.timeout_err !== 1'b0 || ifa.tx_val !== 16'd321) begin
      n_fail++; $display("FAIL t4_stray busy=%b start=%b terr=%b val=%0d exp=0/0/0/321", ifa.busy, ifa.tx_start, ifa.timeout_err, ifa.tx_val);
    end
    ifa.val[47:32] = 16'd42;
    ifa.req = 4'b0100;
    a_wait_start(n);
    n_tests++; if (ifa.tx_start !== 1'b1 || n != 1 || ifa.tx_ch !== 3'd2 || ifa.tx_val !== 16'd42) begin
      n_fail++; $display("FAIL t4_after n=%0d ch=%0d val=%0d exp=1/2/42", n, ifa.tx_ch, ifa.tx_val);
    end
    ifa.req = 4'b0000;
    a_pulse_done();
  endtask

  task automatic test_gap();
    int n;
    bit bad;
    do_reset();
    ifb.val = '0;
    ifb.val[47:32] = 16'd777;
    ifb.req = 4'b0100;
    b_wait_start(n);
    n_tests++; if (ifb.tx_start !== 1'b1 || ifb.tx_ch !== 3'd2 || ifb.tx_val !== 16'd777) begin
      n_fail++; $display("FAIL t5_first start=%b ch=%0d val=%0d exp=1/2/777", ifb.tx_start, ifb.tx_ch, ifb.tx_val);
    end
    repeat (2) @(negedge clk);
    @(negedge clk); ifb.tx_done = 1'b1;
    bad = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) ifb.tx_done = 1'b0;
      if (ifb.busy !== 1'b1 || ifb.tx_start !== 1'b0 || ifb.ack !== 4'b0000) bad = 1'b1;
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL t5_gap_hold got=served_or_idle exp=busy_no_start"); end
    b_wait_start(n);
    n_tests++; if (ifb.tx_start !== 1'b1 || 8 + n != 10) begin n_fail++; $display("FAIL t5_spacing got=%0d exp=10", 8 + n); end
    n_tests++; if (ifb.ack !== 4'b0100 || ifb.tx_ch !== 3'd2) begin n_fail++; $display("FAIL t5_second ack=%b ch=%0d exp=0100/2", ifb.ack, ifb.tx_ch); end
    ifb.req = 4'b0000;
    b_pulse_done();
    repeat (10) @(negedge clk);
    n_tests++; if (ifb.busy !== 1'b0) begin n_fail++; $display("FAIL t5_idle got=%b exp=0", ifb.busy); end
  endtask

  task automatic test_reset_in_wait();
    int n;
    ifa.val = '0;
    ifa.val[15:0] = 16'd100;
    ifa.req = 4'b0001;
    a_wait_start(n);
    ifa.req = 4'b0000;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (ifa.busy !== 1'b0 || ifa.tx_val !== 16'd0 || ifa.tx_ch !== 3'd0) begin
      n_fail++; $display("FAIL t6_rst busy=%b val=%0d ch=%0d exp=0/0/0", ifa.busy, ifa.tx_val, ifa.tx_ch);
    end
    a_pulse_done();
    n_tests++; if (ifa.busy !== 1'b0 || ifa.tx_start !== 1'b0 || ifa.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL t6_late_done busy=%b start=%b terr=%b exp=0/0/0", ifa.busy, ifa.tx_start, ifa.timeout_err);
    end
    ifa.val[31:16] = 16'd200;
    ifa.req = 4'b0011;
    a_wait_start(n);
    n_tests++; if (ifa.tx_start !== 1'b1 || n != 1 || ifa.ack !== 4'b0001) begin n_fail++; $display("FAIL t6_prio n=%0d ack=%b exp=1/0001", n, ifa.ack); end
    ifa.req = 4'b0010;
    a_pulse_done();
    a_wait_start(n);
    n_tests++; if (ifa.tx_start !== 1'b1 || ifa.tx_ch !== 3'd1 || ifa.ack !== 4'b0010 || ifa.tx_val !== 16'd200) begin
      n_fail++; $display("FAIL t6_ch1 ch=%0d ack=%b val=%0d exp=1/0010/200", ifa.tx_ch, ifa.ack, ifa.tx_val);
    end
    ifa.req = 4'b0000;
    ifa.val[31:16] = 16'd999;
    @(negedge clk);
    n_tests++; if (ifa.tx_val !== 16'd200) begin n_fail++; $display("FAIL t6_val_hold got=%0d exp=200", ifa.tx_val); end
    a_pulse_done();
  endtask

  initial begin
    ifa.req = '0; ifa.val = '0; ifa.tx_done = 1'b0;
    ifb.req = '0; ifb.val = '0; ifb.tx_done = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_done_vs_timeout();
    test_gap();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
